// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline registers with valid bit, per-stage stall/flush
// and automatic bubble insertion. Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic [DEPTH-1:0]          stall_i,
  input  logic [DEPTH-1:0]          flush_i,
  output logic                      accept_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [DEPTH*CTRL_W-1:0]   ctrl_o,
  output logic [DEPTH*WIDTH-1:0]    data_o,
  output logic [CNT_W-1:0]          bubble_cnt_o,
  output logic [CNT_W-1:0]          flush_cnt_o
);

  logic [DEPTH-1:0]             hold;
  logic [DEPTH-1:0]             bubble;
  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             up_valid;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][CTRL_W-1:0] up_ctrl;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q;
  logic [DEPTH-1:0][WIDTH-1:0]  up_data;

  // A stall propagates towards stage 0: walk from the last stage downwards.
  always_comb begin : hold_chain
    logic h;
    h    = 1'b0;
    hold = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      h                 = h | stall_i[DEPTH-1-i];
      hold[DEPTH-1-i]   = h;
    end
  end

  always_comb begin
    bubble = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      bubble[k] = hold[k-1] & ~hold[k];
    end
  end

  always_comb begin
    up_valid    = '0;
    up_ctrl     = '0;
    up_data     = '0;
    up_valid[0] = valid_i;
    up_ctrl[0]  = ctrl_i;
    up_data[0]  = data_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      up_valid[k] = valid_q[k-1];
      up_ctrl[k]  = ctrl_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (flush_i[k]) begin
          valid_q[k] <= 1'b0;
          ctrl_q[k]  <= '0;
        end else if (!hold[k]) begin
          if (bubble[k]) begin
            valid_q[k] <= 1'b0;
            ctrl_q[k]  <= '0;
          end else begin
            valid_q[k] <= up_valid[k];
            ctrl_q[k]  <= up_ctrl[k];
            data_q[k]  <= up_data[k];
          end
        end
      end
    end
  end

  assign accept_o = ~hold[0];
  assign valid_o  = valid_q;
  assign ctrl_o   = ctrl_q;
  assign data_o   = data_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [DEPTH-1:0] take_bubble;

  // A flushed stage does not count as taking a bubble, flush has priority.
  assign take_bubble = bubble & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if ((|take_bubble) && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      if ((|flush_i) && (flush_cnt_q != '1))      flush_cnt_q  <= flush_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`else
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (DEPTH=3, WIDTH=32, CTRL_W=4, CNT_W=2): directed table,
// perf-counter sequence and random stimulus against a rule-level reference model.
module tb_pipe_stage_chain;
  localparam int D = 3;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = 2;
  localparam int CMAX = (1 << N) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           vin;
  logic [C-1:0]   cin;
  logic [W-1:0]   din;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic           accept;
  logic [D-1:0]   vout;
  logic [D*C-1:0] cout;
  logic [D*W-1:0] dout;
  logic [N-1:0]   bcnt;
  logic [N-1:0]   fcnt;

  int tests = 0;
  int fails = 0;

  pipe_stage_chain #(.WIDTH(W), .CTRL_W(C), .DEPTH(D), .CNT_W(N)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .ctrl_i(cin), .data_i(din),
    .stall_i(stall), .flush_i(flush), .accept_o(accept), .valid_o(vout),
    .ctrl_o(cout), .data_o(dout), .bubble_cnt_o(bcnt), .flush_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic         mv [D];
  logic [C-1:0] mc [D];
  logic [W-1:0] md [D];
  int           mb;
  int           mf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit held(input int k, input logic [D-1:0] st);
    return (st >> k) != 0;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [C-1:0] c,
                            input logic [W-1:0] d, input logic [D-1:0] st,
                            input logic [D-1:0] fl);
    logic         ov [D];
    logic [C-1:0] oc [D];
    logic [W-1:0] od [D];
    bit took;
    if (r) begin
      for (int k = 0; k < D; k++) begin mv[k] = 1'b0; mc[k] = '0; md[k] = '0; end
      mb = 0;
      mf = 0;
    end else begin
      ov = mv; oc = mc; od = md;
      took = 0;
      for (int k = 0; k < D; k++) begin
        if (fl[k]) begin
          mv[k] = 1'b0; mc[k] = '0;
        end else if (held(k, st)) begin
          mv[k] = ov[k];
        end else if (k > 0 && held(k - 1, st)) begin
          mv[k] = 1'b0; mc[k] = '0; took = 1;
        end else if (k == 0) begin
          mv[0] = v; mc[0] = c; md[0] = d;
        end else begin
          mv[k] = ov[k-1]; mc[k] = oc[k-1]; md[k] = od[k-1];
        end
      end
      if (took && mb < CMAX) mb++;
      if (fl != 0 && mf < CMAX) mf++;
    end
  endtask

  task automatic compare_model();
    logic [D-1:0]   ev;
    logic [D*C-1:0] ec;
    logic [D*W-1:0] ed;
    int eb, ef;
    for (int k = 0; k < D; k++) begin
      ev[k] = mv[k];
      ec[k*C +: C] = mc[k];
      ed[k*W +: W] = md[k];
    end
`ifdef PIPE_PERF_CNT_EN
    eb = mb; ef = mf;
`else
    eb = 0; ef = 0;
`endif
    chk("model_valid", 128'(vout), 128'(ev));
    chk("model_ctrl", 128'(cout), 128'(ec));
    chk("model_data", 128'(dout), 128'(ed));
    chk("model_bubble_cnt", 128'(bcnt), 128'(eb));
    chk("model_flush_cnt", 128'(fcnt), 128'(ef));
  endtask

  // Drive one cycle: check accept before the edge, advance the model, compare after.
  task automatic cycle(input logic r, input logic v, input logic [C-1:0] c,
                       input logic [W-1:0] d, input logic [D-1:0] st, input logic [D-1:0] fl);
    rst = r; vin = v; cin = c; din = d; stall = st; flush = fl;
    #1;
    chk("model_accept", 128'(accept), 128'(st == 0));
    @(posedge clk);
    model_edge(r, v, c, d, st, fl);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic         rst;
    logic         vin;
    logic [3:0]   ctrl;
    logic [31:0]  data;
    logic [2:0]   stall;
    logic [2:0]   flush;
    logic         acc;
    logic [2:0]   ev;
    logic [11:0]  ec;
    logic [95:0]  ed;
  } vec_t;

  vec_t tv [13];

  initial begin
    rst = 1'b1; vin = 1'b1; cin = 4'hF; din = '0; stall = '0; flush = '0;
    for (int k = 0; k < D; k++) begin mv[k] = 1'b0; mc[k] = '0; md[k] = '0; end
    mb = 0; mf = 0;

    //            rst   vin   ctrl   data    stall   flush   acc   valid   ctrl     data {s2,s1,s0}
    tv[0]  = '{1'b1, 1'b1, 4'hF, 32'hAA, 3'b000, 3'b000, 1'b1, 3'b000, 12'h000, {32'h00, 32'h00, 32'h00}};
    tv[1]  = '{1'b1, 1'b1, 4'hF, 32'hAA, 3'b000, 3'b000, 1'b1, 3'b000, 12'h000, {32'h00, 32'h00, 32'h00}};
    tv[2]  = '{1'b0, 1'b1, 4'hF, 32'h10, 3'b000, 3'b000, 1'b1, 3'b001, 12'h00F, {32'h00, 32'h00, 32'h10}};
    tv[3]  = '{1'b0, 1'b1, 4'hF, 32'h20, 3'b000, 3'b000, 1'b1, 3'b011, 12'h0FF, {32'h00, 32'h10, 32'h20}};
    tv[4]  = '{1'b0, 1'b1, 4'hF, 32'h30, 3'b000, 3'b000, 1'b1, 3'b111, 12'hFFF, {32'h10, 32'h20, 32'h30}};
    tv[5]  = '{1'b0, 1'b1, 4'hF, 32'h40, 3'b001, 3'b000, 1'b0, 3'b101, 12'hF0F, {32'h20, 32'h20, 32'h30}};
    tv[6]  = '{1'b0, 1'b1, 4'hF, 32'h50, 3'b100, 3'b000, 1'b0, 3'b101, 12'hF0F, {32'h20, 32'h20, 32'h30}};
    tv[7]  = '{1'b0, 1'b1, 4'hF, 32'h50, 3'b000, 3'b001, 1'b1, 3'b010, 12'h0F0, {32'h20, 32'h30, 32'h30}};
    tv[8]  = '{1'b0, 1'b1, 4'hF, 32'h60, 3'b001, 3'b011, 1'b0, 3'b100, 12'hF00, {32'h30, 32'h30, 32'h30}};
    tv[9]  = '{1'b0, 1'b1, 4'hA, 32'h60, 3'b000, 3'b000, 1'b1, 3'b001, 12'h00A, {32'h30, 32'h30, 32'h60}};
    tv[10] = '{1'b0, 1'b1, 4'h5, 32'h70, 3'b010, 3'b000, 1'b0, 3'b001, 12'h00A, {32'h30, 32'h30, 32'h60}};
    tv[11] = '{1'b0, 1'b0, 4'h5, 32'h70, 3'b000, 3'b000, 1'b1, 3'b010, 12'h0A5, {32'h30, 32'h60, 32'h70}};
    tv[12] = '{1'b1, 1'b1, 4'hF, 32'h80, 3'b111, 3'b000, 1'b0, 3'b000, 12'h000, {32'h00, 32'h00, 32'h00}};

    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; vin = tv[i].vin; cin = tv[i].ctrl; din = tv[i].data;
      stall = tv[i].stall; flush = tv[i].flush;
      #1;
      chk($sformatf("vec%0d_accept", i), 128'(accept), 128'(tv[i].acc));
      @(posedge clk);
      model_edge(tv[i].rst, tv[i].vin, tv[i].ctrl, tv[i].data, tv[i].stall, tv[i].flush);
      #1;
      chk($sformatf("vec%0d_valid", i), 128'(vout), 128'(tv[i].ev));
      chk($sformatf("vec%0d_ctrl", i), 128'(cout), 128'(tv[i].ec));
      chk($sformatf("vec%0d_data", i), 128'(dout), 128'(tv[i].ed));
      compare_model();
    end

    // Bubble counter saturation, mid-run reset, flush counting
    cycle(1'b1, 1'b1, 4'h3, 32'h1, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'h3, 32'h100 + 32'(i), 3'b001, 3'b000);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_bubble_sat", 128'(bcnt), 128'(3));
`else
    chk("perf_bubble_off", 128'(bcnt), 128'(0));
`endif
    cycle(1'b1, 1'b1, 4'h3, 32'h2, 3'b000, 3'b000);
    chk("perf_bubble_reset", 128'(bcnt), 128'(0));
    cycle(1'b0, 1'b1, 4'h3, 32'h3, 3'b000, 3'b001);
    cycle(1'b0, 1'b1, 4'h3, 32'h4, 3'b000, 3'b010);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_flush_cnt", 128'(fcnt), 128'(2));
`else
    chk("perf_flush_off", 128'(fcnt), 128'(0));
`endif
    chk("perf_bubble_none", 128'(bcnt), 128'(0));

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      logic [D-1:0] st, fl;
      for (int k = 0; k < D; k++) begin
        st[k] = ($urandom_range(0, 4) == 0);
        fl[k] = ($urandom_range(0, 7) == 0);
      end
      cycle($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), $urandom, st, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
